test_completion_monitor: RTL and testbench
==========================================

TEST_COMPLETION_MONITOR -- requirements
Module: test_completion_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of success/failure channels, range 1..32.
REQ-002 SHALL have parameter CNT_W, default 64: width of the cycle counter and timeout limit.
REQ-003 SHALL have parameter WDOG_W, default 16: width of the watchdog counter and limit.
REQ-004 SHALL have parameter RST_HOLD, default 8: number of cycles DUT reset is held after entering HOLD, minimum 1.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 clock  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-low; 0 sampled at a rising edge forces the reset state.
REQ-008 ch_enable  in  N_CH  per-channel participation mask.
REQ-009 ch_success  in  N_CH  per-channel success pulse or level.
REQ-010 ch_failure  in  N_CH  per-channel failure pulse or level.
REQ-011 ch_heartbeat  in  N_CH  per-channel progress indication.
REQ-012 mode_any  in  1  0 = pass needs every enabled channel; 1 = pass needs any enabled channel.
REQ-013 max_cycles  in  CNT_W  timeout limit; 0 disables the timeout.
REQ-014 wdog_limit  in  WDOG_W  watchdog limit; 0 disables the watchdog.
REQ-015 clear  in  1  restarts a finished run.
REQ-016 dut_reset  out  1  active-high reset to the device under test.
REQ-017 done  out  1  run finished.
REQ-018 pass  out  1  run finished successfully.
REQ-019 fail_code  out  2  0 none, 1 channel failure, 2 timeout, 3 watchdog.
REQ-020 fail_ch  out  max(1,clog2(N_CH))  lowest failing channel index, valid only when fail_code=1.
REQ-021 cycle_count  out  CNT_W  number of completed RUN cycles.
REQ-022 success_seen  out  N_CH  sticky per-channel success record.

Function
REQ-023 SHALL implement the states HOLD, RUN, PASS and FAIL; every output SHALL be a register.
REQ-024 HOLD behaviour:
- dut_reset=1 for exactly RST_HOLD cycles, counted from HOLD entry.
- In HOLD, cycle_count, success_seen, fail_code, fail_ch and the watchdog counter are 0.
- After the RST_HOLD cycles, the state moves to RUN and dut_reset=0.
REQ-025 Each RUN cycle SHALL evaluate, in this priority: channel failure, then timeout, then watchdog, then pass.
REQ-026 Channel failure: any bit of (ch_failure & ch_enable) set -> FAIL, fail_code=1, fail_ch = lowest such index.
REQ-027 Timeout: max_cycles≠0 and cycle_count==max_cycles, with no higher-priority event -> FAIL, fail_code=2.
REQ-028 Watchdog counter behaviour:
- Clears in any RUN cycle with any bit of (ch_heartbeat & ch_enable) set.
- Otherwise increments, saturating at all-ones.
- wdog_limit≠0 and counter==wdog_limit -> FAIL, fail_code=3.
REQ-029 success_seen |= (ch_success & ch_enable) each RUN cycle; the term includes same-cycle inputs.
REQ-030 Pass condition and outcome:
- mode_any=0: all enabled bits are set in the updated success_seen.
- mode_any=1: any enabled bit is set in the updated success_seen.
- With ch_enable=0, pass never fires.
- On pass -> PASS, pass=1.
REQ-031 cycle_count SHALL increment only in RUN cycles with no terminal event, saturating at all-ones.
REQ-032 done SHALL be 1 in PASS and FAIL; PASS and FAIL SHALL be sticky, and cycle_count, fail_code, fail_ch and success_seen SHALL freeze there.
REQ-033 clear=1 in PASS or FAIL SHALL enter HOLD the next cycle, re-running the reset sequence; clear SHALL be ignored in HOLD and RUN.
REQ-034 Failure and success in the same cycle SHALL resolve to FAIL.
REQ-035 Inputs sampled in HOLD SHALL have no effect.

Reset
REQ-036 reset=0 at any edge, including mid-RUN or in PASS/FAIL, SHALL enter HOLD with all counters cleared.
REQ-037 Output values while reset is asserted and on the first cycle after release:
- dut_reset=1.
- done=0, pass=0, fail_code=0, fail_ch=0, cycle_count=0, success_seen=0.
REQ-038 RST_HOLD counting SHALL begin on the first edge with reset=1.

Verification
REQ-039 N_CH=4, ch_enable=4'b1111, mode_any=0; successes on ch0..ch3 spread over RUN cycles 10..13 -> PASS after cycle 13, with cycle_count=13.
REQ-040 max_cycles=100, no success -> FAIL with fail_code=2, cycle_count=100; done stays 1 until clear.
REQ-041 ch_failure=4'b0110 and ch_success=4'b1111 in the same cycle -> FAIL with fail_code=1, fail_ch=1, pass=0.
REQ-042 wdog_limit=5, heartbeats stopped -> FAIL with fail_code=3 on the 6th consecutive silent cycle; one heartbeat on silent cycle 4 delays the failure by 4 more cycles.
REQ-043 reset=0 held for one cycle mid-RUN at cycle_count=50 -> dut_reset=1 for RST_HOLD cycles, then RUN with cycle_count restarting from 0.
REQ-044 mode_any=1, ch_enable=4'b0100, success on ch0 -> ignored; success on ch2 -> PASS.

Source files
------------

// File: rtl/test_completion_monitor.sv
// Test completion monitor: holds a device under test in reset, then watches
// per-channel success/failure/heartbeat signals until the run passes or fails.
module test_completion_monitor #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 64,
  parameter int WDOG_W   = 16,
  parameter int RST_HOLD = 8,
  localparam int FCW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_CH-1:0]   ch_enable,
  input  logic [N_CH-1:0]   ch_success,
  input  logic [N_CH-1:0]   ch_failure,
  input  logic [N_CH-1:0]   ch_heartbeat,
  input  logic              mode_any,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic [WDOG_W-1:0] wdog_limit,
  input  logic              clear,
  output logic              dut_reset,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [FCW-1:0]    fail_ch,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [N_CH-1:0]   success_seen
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_t;

  state_t            state;
  logic [HW-1:0]     hold_cnt;
  logic [WDOG_W-1:0] wdog_cnt;

  logic [N_CH-1:0] seen_next;
  logic [N_CH-1:0] chan_fail;
  logic            heartbeat_hit;
  logic            pass_hit;
  logic            timeout_hit;
  logic            wdog_hit;
  logic            finished;
  logic            go_hold;
  logic [FCW-1:0]  lowest_fail;

  // Success bits seen this cycle count towards the pass decision immediately.
  assign seen_next     = success_seen | (ch_success & ch_enable);
  assign chan_fail     = ch_failure & ch_enable;
  assign heartbeat_hit = |(ch_heartbeat & ch_enable);
  assign pass_hit      = (ch_enable != '0) &&
                         (mode_any ? |(seen_next & ch_enable)
                                   : ((seen_next & ch_enable) == ch_enable));
  assign timeout_hit   = (max_cycles != '0) && (cycle_count == max_cycles);
  assign wdog_hit      = (wdog_limit != '0) && (wdog_cnt == wdog_limit);
  assign finished      = (state == ST_PASS) || (state == ST_FAIL);
  assign go_hold       = !reset || (finished && clear);

  always_comb begin
    lowest_fail = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (chan_fail[i]) lowest_fail = FCW'(i);
    end
  end

  // Reset and clear share the same entry into HOLD so the DUT reset sequence
  // always restarts from a clean record.
  always_ff @(posedge clock) begin
    if (go_hold) begin
      state        <= ST_HOLD;
      hold_cnt     <= '0;
      wdog_cnt     <= '0;
      dut_reset    <= 1'b1;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_code    <= 2'd0;
      fail_ch      <= '0;
      cycle_count  <= '0;
      success_seen <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HW'(RST_HOLD - 1)) begin
            state     <= ST_RUN;
            dut_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_RUN: begin
          success_seen <= seen_next;
          if (heartbeat_hit) wdog_cnt <= '0;
          else if (wdog_cnt != '1) wdog_cnt <= wdog_cnt + WDOG_W'(1);
          // Terminal events in priority order; only a quiet cycle is counted.
          if (chan_fail != '0) begin
            state     <= ST_FAIL;
            done      <= 1'b1;
            fail_code <= 2'd1;
            fail_ch   <= lowest_fail;
          end else if (timeout_hit) begin
            state     <= ST_FAIL;
            done      <= 1'b1;
            fail_code <= 2'd2;
          end else if (wdog_hit) begin
            state     <= ST_FAIL;
            done      <= 1'b1;
            fail_code <= 2'd3;
          end else if (pass_hit) begin
            state <= ST_PASS;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        ST_PASS, ST_FAIL: begin
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_test_completion_monitor.sv
// Self-checking bench for test_completion_monitor: a behavioural model is
// compared every cycle, and directed scenarios pin key results to literals.
module tb_test_completion_monitor;

  localparam int N_CH     = 4;
  localparam int CNT_W    = 64;
  localparam int WDOG_W   = 16;
  localparam int RST_HOLD = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [N_CH-1:0]   ch_enable;
  logic [N_CH-1:0]   ch_success;
  logic [N_CH-1:0]   ch_failure;
  logic [N_CH-1:0]   ch_heartbeat;
  logic              mode_any;
  logic [CNT_W-1:0]  max_cycles;
  logic [WDOG_W-1:0] wdog_limit;
  logic              clear;
  logic              dut_reset;
  logic              done;
  logic              pass;
  logic [1:0]        fail_code;
  logic [1:0]        fail_ch;
  logic [CNT_W-1:0]  cycle_count;
  logic [N_CH-1:0]   success_seen;

  int checks = 0;
  int failures = 0;

  test_completion_monitor #(
    .N_CH(N_CH), .CNT_W(CNT_W), .WDOG_W(WDOG_W), .RST_HOLD(RST_HOLD)
  ) dut (
    .clock(clock), .reset(reset), .ch_enable(ch_enable), .ch_success(ch_success),
    .ch_failure(ch_failure), .ch_heartbeat(ch_heartbeat), .mode_any(mode_any),
    .max_cycles(max_cycles), .wdog_limit(wdog_limit), .clear(clear),
    .dut_reset(dut_reset), .done(done), .pass(pass), .fail_code(fail_code),
    .fail_ch(fail_ch), .cycle_count(cycle_count), .success_seen(success_seen)
  );

  always #5 clock = ~clock;

  // Model: phase 0 = holding DUT in reset, 1 = running, 2 = passed, 3 = failed.
  int               m_phase;
  int               m_hold_left;
  logic [CNT_W-1:0] m_count;
  int               m_silent;
  logic [N_CH-1:0]  m_seen;
  int               m_code;
  int               m_ch;
  bit               m_valid = 0;

  task automatic model_enter_hold();
    m_phase = 0; m_hold_left = RST_HOLD; m_count = '0; m_silent = 0;
    m_seen = '0; m_code = 0; m_ch = 0;
  endtask

  always @(posedge clock) begin
    if (!reset) begin
      model_enter_hold();
      m_valid = 1;
    end else if (m_valid) begin
      if (m_phase == 0) begin
        m_hold_left--;
        if (m_hold_left == 0) m_phase = 1;
      end else if (m_phase == 1) begin
        int first_bad;
        bit all_done;
        bit any_done;
        bit any_beat;
        int prev_silent;
        first_bad = -1; all_done = 1; any_done = 0; any_beat = 0;
        m_seen = m_seen | (ch_success & ch_enable);
        for (int i = 0; i < N_CH; i++) begin
          if (ch_enable[i]) begin
            if (ch_failure[i] && first_bad < 0) first_bad = i;
            if (m_seen[i]) any_done = 1; else all_done = 0;
            if (ch_heartbeat[i]) any_beat = 1;
          end
        end
        if (ch_enable == '0) begin all_done = 0; any_done = 0; end
        prev_silent = m_silent;
        m_silent = any_beat ? 0 : ((m_silent < 65535) ? m_silent + 1 : m_silent);
        if (first_bad >= 0) begin m_phase = 3; m_code = 1; m_ch = first_bad; end
        else if (max_cycles != 0 && m_count == max_cycles) begin m_phase = 3; m_code = 2; end
        else if (wdog_limit != 0 && prev_silent == int'(wdog_limit)) begin m_phase = 3; m_code = 3; end
        else if (mode_any ? any_done : all_done) m_phase = 2;
        else if (m_count != {CNT_W{1'b1}}) m_count = m_count + 1;
      end else if (clear) begin
        model_enter_hold();
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (m_valid) begin
      checkOutput("m.dut_reset", 64'(dut_reset), 64'(m_phase == 0));
      checkOutput("m.done", 64'(done), 64'(m_phase >= 2));
      checkOutput("m.pass", 64'(pass), 64'(m_phase == 2));
      checkOutput("m.fail_code", 64'(fail_code), 64'(m_code));
      checkOutput("m.fail_ch", 64'(fail_ch), 64'(m_ch));
      checkOutput("m.cycle_count", cycle_count, m_count);
      checkOutput("m.success_seen", 64'(success_seen), 64'(m_seen));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] en, input logic [N_CH-1:0] succ,
                               input logic [N_CH-1:0] fl, input logic [N_CH-1:0] hb);
    ch_enable = en; ch_success = succ; ch_failure = fl; ch_heartbeat = hb;
  endtask

  // Clear a finished run, keep clear high into HOLD, and return once in RUN.
  task automatic restart();
    clear = 1'b1;
    tick(2);
    clear = 1'b0;
    tick(RST_HOLD - 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout simulation did not finish");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    reset = 1'b0; clear = 1'b0; mode_any = 1'b0; max_cycles = '0; wdog_limit = '0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(2);
    checkOutput("rst.dut_reset", 64'(dut_reset), 64'd1);
    checkOutput("rst.done", 64'(done), 64'd0);
    checkOutput("rst.cycle_count", cycle_count, 64'd0);
    reset = 1'b1;
    tick(RST_HOLD - 1);
    checkOutput("hold.dut_reset_last", 64'(dut_reset), 64'd1);
    tick(1);
    checkOutput("hold.dut_reset_released", 64'(dut_reset), 64'd0);

    $display("[TB] all-channel pass");
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    tick(10);
    applyStimulus(4'b1111, 4'b0001, 4'b0000, 4'b0000); tick(1);
    applyStimulus(4'b1111, 4'b0010, 4'b0000, 4'b0000); tick(1);
    applyStimulus(4'b1111, 4'b0100, 4'b0000, 4'b0000); tick(1);
    checkOutput("allpass.not_yet", 64'(done), 64'd0);
    applyStimulus(4'b1111, 4'b1000, 4'b0000, 4'b0000); tick(1);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("allpass.pass", 64'(pass), 64'd1);
    checkOutput("allpass.cycle_count", cycle_count, 64'd13);
    checkOutput("allpass.seen", 64'(success_seen), 64'hF);

    $display("[TB] timeout");
    max_cycles = 64'd100;
    restart();
    tick(100);
    checkOutput("timeout.not_yet", 64'(done), 64'd0);
    tick(1);
    checkOutput("timeout.code", 64'(fail_code), 64'd2);
    checkOutput("timeout.cycle_count", cycle_count, 64'd100);
    tick(5);
    checkOutput("timeout.sticky", 64'(done), 64'd1);

    $display("[TB] failure beats success");
    max_cycles = '0;
    restart();
    tick(2);
    applyStimulus(4'b1111, 4'b1111, 4'b0110, 4'b0000); tick(1);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("chfail.code", 64'(fail_code), 64'd1);
    checkOutput("chfail.ch", 64'(fail_ch), 64'd1);
    checkOutput("chfail.pass", 64'(pass), 64'd0);

    $display("[TB] watchdog");
    wdog_limit = 16'd5;
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b1111);
    restart();
    tick(3);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    tick(5);
    checkOutput("wdog.not_yet", 64'(done), 64'd0);
    tick(1);
    checkOutput("wdog.code", 64'(fail_code), 64'd3);
    checkOutput("wdog.cycle_count", cycle_count, 64'd8);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b1111);
    restart();
    tick(3);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000); tick(3);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b1111); tick(1);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000); tick(5);
    checkOutput("wdog_hb.not_yet", 64'(done), 64'd0);
    tick(1);
    checkOutput("wdog_hb.code", 64'(fail_code), 64'd3);
    checkOutput("wdog_hb.cycle_count", cycle_count, 64'd12);

    $display("[TB] reset mid-run");
    wdog_limit = '0;
    restart();
    tick(50);
    checkOutput("midrst.before", cycle_count, 64'd50);
    reset = 1'b0; tick(1); reset = 1'b1;
    checkOutput("midrst.dut_reset", 64'(dut_reset), 64'd1);
    checkOutput("midrst.cleared", cycle_count, 64'd0);
    applyStimulus(4'b1111, 4'b0000, 4'b1111, 4'b0000);
    tick(RST_HOLD - 1);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("midrst.still_held", 64'(dut_reset), 64'd1);
    tick(1);
    checkOutput("midrst.released", 64'(dut_reset), 64'd0);
    checkOutput("midrst.hold_inputs_ignored", 64'(done), 64'd0);
    tick(3);
    checkOutput("midrst.restart_count", cycle_count, 64'd3);

    $display("[TB] any-mode and empty enable");
    applyStimulus(4'b0000, 4'b1111, 4'b0000, 4'b0000); tick(5);
    checkOutput("noenable.no_pass", 64'(done), 64'd0);
    mode_any = 1'b1;
    clear = 1'b1;
    applyStimulus(4'b0100, 4'b0001, 4'b0000, 4'b0000); tick(2);
    clear = 1'b0;
    checkOutput("any.ignored", 64'(success_seen), 64'h0);
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 4'b0000); tick(1);
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("any.pass", 64'(pass), 64'd1);
    checkOutput("any.cycle_count", cycle_count, 64'd10);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
